// File: rtl/stopwatch_cu.sv
`timescale 1ns/1ps
// Stopwatch control unit: debounced buttons (+ UART 'R'/'C' commands when STOPWATCH_CU_UART_CMD_EN
// is defined) drive a STOP/RUN/CLEAR Moore FSM; o_run/o_clear/o_state decode straight from the state flop.
module stopwatch_cu #(
    parameter int DB_DIV   = 100000,
    parameter int DB_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_state
);

    localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    logic [1:0]          run_sync_q, run_sync_d;
    logic [1:0]          clr_sync_q, clr_sync_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick;
    logic [DB_DEPTH-1:0] run_sh_q, run_sh_d;
    logic [DB_DEPTH-1:0] clr_sh_q, clr_sh_d;
    logic                run_db_q, run_db_d;
    logic                clr_db_q, clr_db_d;
    logic                run_db_d1_q, clr_db_d1_q;
    logic                uart_run_q, uart_run_d;
    logic                uart_clr_q, uart_clr_d;
    logic                ev_run, ev_clear;
    state_t              state_q, state_d;

    assign tick = (cnt_q == CW'(DB_DIV - 1));

    always_comb begin
        run_sync_d = {run_sync_q[0], i_btn_run};
        clr_sync_d = {clr_sync_q[0], i_btn_clear};
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        run_sh_d   = run_sh_q;
        clr_sh_d   = clr_sh_q;
        if (tick) begin
            run_sh_d = {run_sh_q[DB_DEPTH-2:0], run_sync_q[1]};
            clr_sh_d = {clr_sh_q[DB_DEPTH-2:0], clr_sync_q[1]};
        end
        // Debounced level only moves on a unanimous window; mixed windows hold it.
        run_db_d = run_db_q;
        if (&run_sh_q)       run_db_d = 1'b1;
        else if (~|run_sh_q) run_db_d = 1'b0;
        clr_db_d = clr_db_q;
        if (&clr_sh_q)       clr_db_d = 1'b1;
        else if (~|clr_sh_q) clr_db_d = 1'b0;
    end

`ifdef STOPWATCH_CU_UART_CMD_EN
    always_comb begin
        uart_run_d = i_rx_done && ((i_rx_data == 8'h52) || (i_rx_data == 8'h72));
        uart_clr_d = i_rx_done && ((i_rx_data == 8'h43) || (i_rx_data == 8'h63));
    end
`else
    logic unused_rx;
    assign unused_rx  = ^{i_rx_data, i_rx_done};
    assign uart_run_d = 1'b0;
    assign uart_clr_d = 1'b0;
`endif

    assign ev_run   = (run_db_q & ~run_db_d1_q) | uart_run_q;
    assign ev_clear = (clr_db_q & ~clr_db_d1_q) | uart_clr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (ev_clear)    state_d = ST_CLEAR;
                else if (ev_run) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Clear requests are deliberately ignored while counting.
                if (ev_run) state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync_q  <= '0;
            clr_sync_q  <= '0;
            cnt_q       <= '0;
            run_sh_q    <= '0;
            clr_sh_q    <= '0;
            run_db_q    <= 1'b0;
            clr_db_q    <= 1'b0;
            run_db_d1_q <= 1'b0;
            clr_db_d1_q <= 1'b0;
            uart_run_q  <= 1'b0;
            uart_clr_q  <= 1'b0;
            state_q     <= ST_STOP;
        end else begin
            run_sync_q  <= run_sync_d;
            clr_sync_q  <= clr_sync_d;
            cnt_q       <= cnt_d;
            run_sh_q    <= run_sh_d;
            clr_sh_q    <= clr_sh_d;
            run_db_q    <= run_db_d;
            clr_db_q    <= clr_db_d;
            run_db_d1_q <= run_db_q;
            clr_db_d1_q <= clr_db_q;
            uart_run_q  <= uart_run_d;
            uart_clr_q  <= uart_clr_d;
            state_q     <= state_d;
        end
    end

    assign o_run   = (state_q == ST_RUN);
    assign o_clear = (state_q == ST_CLEAR);
    assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
`timescale 1ns/1ps
// Scoreboard bench for stopwatch_cu: expected state transitions are queued by the stimulus,
// and a negedge monitor pops one entry for every o_state change it observes.
module tb_stopwatch_cu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       o_run;
    logic       o_clear;
    logic [1:0] o_state;

    int n_vec  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];
    logic [1:0] prev_state = 2'b00;

    always #5 clk = ~clk;

    stopwatch_cu #(.DB_DIV(4), .DB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_btn_run(i_btn_run), .i_btn_clear(i_btn_clear),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_run(o_run), .o_clear(o_clear), .o_state(o_state)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every visible state change must match the next queued expectation.
    always @(negedge clk) begin
        if (o_state !== prev_state) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_transition: got state %b expected no change at %0t", o_state, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (o_state !== e) begin
                    n_fail++;
                    $display("FAIL state_seq: got %b expected %b at %0t", o_state, e, $time);
                end
            end
            check("run_decode", {7'd0, o_run}, {7'd0, (o_state == 2'b01)});
            check("clear_decode", {7'd0, o_clear}, {7'd0, (o_state == 2'b10)});
            prev_state = o_state;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_run(input int hold);
        i_btn_run = 1'b1;
        cyc(hold);
        i_btn_run = 1'b0;
        cyc(60);
    endtask

    task automatic press_clear(input int hold);
        i_btn_clear = 1'b1;
        cyc(hold);
        i_btn_clear = 1'b0;
        cyc(60);
    endtask

    initial begin
        #1;
        check("rst_run", {7'd0, o_run}, 8'd0);
        check("rst_clear", {7'd0, o_clear}, 8'd0);
        check("rst_state", {6'd0, o_state}, 8'd0);
        cyc(3);
        rst = 1'b0;

        // Idle: any transition would be flagged by the monitor.
        cyc(200);
        check("idle_run", {7'd0, o_run}, 8'd0);
        check("idle_clear", {7'd0, o_clear}, 8'd0);
        check("idle_state", {6'd0, o_state}, 8'd0);

        // Run press starts, held/released stays running, second press stops.
        exp_q.push_back(2'b01);
        press_run(100);
        check("run_after_release", {7'd0, o_run}, 8'd1);
        check("state_running", {6'd0, o_state}, 8'h01);
        exp_q.push_back(2'b00);
        press_run(100);
        check("stopped", {6'd0, o_state}, 8'h00);

        // Bouncing contact then steady high: a single event only.
        exp_q.push_back(2'b01);
        for (int i = 0; i < 10; i++) begin
            i_btn_run = ~i_btn_run;
            cyc(3);
        end
        press_run(100);
        check("bounce_single_toggle", {7'd0, o_run}, 8'd1);

        // Clear while running is ignored.
        press_clear(100);
        check("clear_ignored_run", {7'd0, o_run}, 8'd1);

        // Stop, then clear gives a one-cycle CLEAR then STOP.
        exp_q.push_back(2'b00);
        press_run(100);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        press_clear(100);
        check("after_clear", {6'd0, o_state}, 8'h00);

        // Both buttons together from STOP: clear wins.
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        i_btn_run = 1'b1;
        i_btn_clear = 1'b1;
        cyc(100);
        i_btn_run = 1'b0;
        i_btn_clear = 1'b0;
        cyc(60);
        check("both_run_low", {7'd0, o_run}, 8'd0);

`ifdef STOPWATCH_CU_UART_CMD_EN
        exp_q.push_back(2'b01);
        i_rx_data = 8'h72;
        i_rx_done = 1'b1;
        cyc(1);
        i_rx_done = 1'b0;
        check("uart_r_1st_edge", {7'd0, o_run}, 8'd0);
        cyc(1);
        check("uart_r_2nd_edge", {7'd0, o_run}, 8'd1);
        cyc(10);
        i_rx_data = 8'h43;
        i_rx_done = 1'b1;
        cyc(1);
        i_rx_done = 1'b0;
        cyc(10);
        check("uart_C_ignored", {6'd0, o_state}, 8'h01);
        i_rx_data = 8'h5A;
        i_rx_done = 1'b1;
        cyc(1);
        i_rx_done = 1'b0;
        cyc(10);
        check("uart_Z_ignored", {6'd0, o_state}, 8'h01);
`else
        i_rx_data = 8'h72;
        i_rx_done = 1'b1;
        cyc(1);
        i_rx_done = 1'b0;
        cyc(10);
        check("uart_disabled", {7'd0, o_run}, 8'd0);
        exp_q.push_back(2'b01);
        press_run(100);
        check("run_before_rst", {7'd0, o_run}, 8'd1);
`endif

        // Asynchronous reset mid-cycle while running.
        exp_q.push_back(2'b00);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_run", {7'd0, o_run}, 8'd0);
        check("async_rst_state", {6'd0, o_state}, 8'h00);
        cyc(3);
        rst = 1'b0;
        cyc(50);
        check("post_rst_idle", {6'd0, o_state}, 8'h00);
        exp_q.push_back(2'b01);
        press_run(100);
        check("post_rst_run", {7'd0, o_run}, 8'd1);

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
- Control unit directly upstream of the stopwatch datapath. It produces the `run` and `clear` levels that the datapath's 100 Hz divider and time counters consume.
- Takes raw push-button inputs, debounces them internally and edge-detects them. Optionally also accepts single-byte UART commands.
- A 3-state Moore FSM decides stopped, running or clearing.

Parameters:
- DB_DIV, 100000: clk cycles per debounce sample tick (1 kHz at 100 MHz). Legal range ≥ 2.
- DB_DEPTH, 8: consecutive identical samples required to change a debounced level. Legal range 2..16.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- i_btn_run  input  1  raw run/stop button, asynchronous to clk, active-high
- i_btn_clear  input  1  raw clear button, asynchronous to clk, active-high
- i_rx_data  input  8  received UART byte; valid only when i_rx_done=1
- i_rx_done  input  1  one-cycle strobe qualifying i_rx_data
- o_run  output  1  level: datapath counts while 1
- o_clear  output  1  one-cycle pulse: datapath counters zeroed
- o_state  output  2  current FSM state encoding (debug/LED)

Interface note: one clock (clk); reset rst is asynchronous, active-high.

Behaviour:
- Reset (async, rst=1):
  - FSM = STOP.
  - o_run=0, o_clear=0, o_state=2'b00.
  - Sample divider, shift registers, debounced levels and edge registers all cleared to 0.
- Input sync: each raw button passes through a 2-FF synchronizer before debounce.
- Sample tick:
  - Internal counter 0..DB_DIV-1.
  - One-cycle tick when the counter equals DB_DIV-1, then it wraps to 0.
  - Width is $clog2(DB_DIV).
- Debounce:
  - On each tick, the synchronized level shifts into a DB_DEPTH-bit register.
  - Debounced level goes to 1 when all bits are 1 and to 0 when all bits are 0. Otherwise it holds.
- Edge detect:
  - Event pulse = debounced & ~debounced_d1. Exactly one clk cycle per press.
  - Release generates no event.
- Event merge (`ev_run`, `ev_clear`):
  - `ev_run` = button run event OR UART run command.
  - `ev_clear` = button clear event OR UART clear command.
  - Coincident duplicates collapse to a single event.
- FSM states: STOP=2'b00, RUN=2'b01, CLEAR=2'b10. Transitions are evaluated on posedge clk.
  - STOP:
    - ev_clear -> CLEAR. Clear has priority over ev_run in the same cycle.
    - ev_run only -> RUN.
    - else stay.
  - RUN:
    - ev_run -> STOP.
    - ev_clear is ignored (no clear while running).
    - else stay.
  - CLEAR: unconditional -> STOP after exactly one cycle. Events arriving in this cycle are dropped.
  - Encoding 2'b11 (illegal) -> STOP.
- Outputs are registered Moore decode of the state:
  - o_run=1 iff state==RUN.
  - o_clear=1 iff state==CLEAR.
  - o_state=state.
- Latency:
  - A clean button press reaches o_run after 2 sync cycles plus up to DB_DEPTH ticks, plus 2 cycles (edge + state).
  - A UART command is reflected on o_run/o_clear on the 2nd posedge after the i_rx_done cycle.
- Reset mid-operation: immediate return to STOP with o_run=0. No pending event survives reset.
- Held button: produces one event only. Holding run does not toggle repeatedly.

Optional Feature:
- Macro: STOPWATCH_CU_UART_CMD_EN.
- Defined:
  - When i_rx_done=1, a command is decoded from i_rx_data.
  - 8'h52 'R' / 8'h72 'r' -> UART run event.
  - 8'h43 'C' / 8'h63 'c' -> UART clear event.
  - Any other byte is ignored.
  - Decode is registered: the event is asserted one cycle after i_rx_done.
- Undefined:
  - i_rx_data and i_rx_done are ignored; UART events are tied to 0.
  - The ports remain present so instantiation is unchanged.

Test Plan (DB_DIV=4, DB_DEPTH=4 for sim):
- Reset, no stimulus for 200 cycles -> o_run=0, o_clear=0, o_state=00 throughout.
- Press i_btn_run high for 100 cycles, release -> o_run rises once; stays 1 after release; o_state=01. Press again -> o_run=0, o_state=00.
- i_btn_run bouncing (toggle every 3 cycles for 30 cycles) then steady high -> exactly one ev_run; o_run toggles exactly once.
- In RUN, press i_btn_clear -> o_clear never pulses, o_run stays 1. Stop, then press clear -> o_clear=1 for exactly 1 cycle, then o_state=00.
- In STOP, both buttons pressed identically (same cycle) -> CLEAR wins: one o_clear pulse, o_run remains 0.
- With STOPWATCH_CU_UART_CMD_EN:
  - i_rx_data=8'h72 with a 1-cycle i_rx_done -> o_run=1 two posedges later.
  - 8'h43 sent while running -> ignored.
  - 8'h5A -> no effect.
  - Assert rst while in RUN -> o_run=0 asynchronously.
